// File: rtl/par_ser.sv
// Parallel-to-serial lane transmitter: comma run after reset, then MSB-first bytes with idle fill.
// Define PAR_SER_FIFO_EN to replace the single hold register with a 4-entry FIFO.
module par_ser #(
   parameter int unsigned MIN_COMMA = 4,
   parameter logic [7:0]  IDLE_BYTE = 8'hBC
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       byte_start,
   output logic       active
);

   // state | meaning
   // SYNC  | sending the comma run, no data accepted
   // RUN   | data accepted, idle byte fills empty slots
   localparam logic [0:0] ST_SYNC = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [7:0] LAST_COMMA = 8'(MIN_COMMA - 1);

   logic [0:0] state_q, state_d;
   logic [7:0] comma_cnt_q, comma_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       data_out_q, data_out_d;
   logic       byte_start_q, byte_start_d;
   logic       active_q, active_d;
   logic [7:0] byte_sel;

   logic       load_slot;
   logic       run;
   logic       pop;
   logic       push;
   logic [7:0] head;

   assign load_slot = (bit_cnt_q == 3'd0);
   assign run       = (state_q == ST_RUN);
   assign push      = valid_in && ready_out;

`ifdef PAR_SER_FIFO_EN
   logic [7:0] fifo_q [4];
   logic [1:0] rd_ptr_q, wr_ptr_q;
   logic [2:0] count_q;

   assign pop       = load_slot && run && (count_q != 3'd0);
   assign ready_out = run && ((count_q < 3'd4) || pop);
   assign head      = fifo_q[rd_ptr_q];

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      end else begin
         if (push) begin
            fifo_q[wr_ptr_q] <= data_in;
            wr_ptr_q         <= wr_ptr_q + 2'd1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 3'd1;
            2'b01:   count_q <= count_q - 3'd1;
            default: count_q <= count_q;
         endcase
      end
   end
`else
   logic [7:0] hold_q, hold_d;
   logic       hold_valid_q, hold_valid_d;

   assign pop       = load_slot && run && hold_valid_q;
   // A full hold frees up in a load slot, so a new byte can land as the old one leaves.
   assign ready_out = run && (!hold_valid_q || load_slot);
   assign head      = hold_q;

   always_comb begin
      hold_d       = push ? data_in : hold_q;
      hold_valid_d = push || (hold_valid_q && !pop);
   end

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
      end else begin
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
      end
   end
`endif

   always_comb begin
      state_d      = state_q;
      comma_cnt_d  = comma_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      data_out_d   = data_out_q;
      byte_start_d = byte_start_q;
      active_d     = active_q;
      byte_sel     = IDLE_BYTE;
      if (load_slot) begin
         byte_sel     = pop ? head : IDLE_BYTE;
         data_out_d   = byte_sel[7];
         shift_d      = {byte_sel[6:0], 1'b0};
         bit_cnt_d    = 3'd7;
         byte_start_d = 1'b1;
         // active moves only on slot boundaries so it aligns with byte_start
         active_d     = run;
         if (!run) begin
            comma_cnt_d = comma_cnt_q + 8'd1;
            if (comma_cnt_q == LAST_COMMA) state_d = ST_RUN;
         end
      end else begin
         data_out_d   = shift_q[7];
         shift_d      = {shift_q[6:0], 1'b0};
         bit_cnt_d    = bit_cnt_q - 3'd1;
         byte_start_d = 1'b0;
      end
   end

   always_ff @(posedge clk_32f) begin
      if (reset) begin
         state_q      <= ST_SYNC;
         comma_cnt_q  <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         data_out_q   <= 1'b0;
         byte_start_q <= 1'b0;
         active_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         comma_cnt_q  <= comma_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         data_out_q   <= data_out_d;
         byte_start_q <= byte_start_d;
         active_q     <= active_d;
      end
   end

   assign data_out   = data_out_q;
   assign byte_start = byte_start_q;
   assign active     = active_q;

endmodule

// File: tb/tb_par_ser.sv
// Bench for par_ser: timeline model (byte slots since reset release plus a pending-byte queue)
// checked every cycle, with literal checks on the stream and a MIN_COMMA=1 instance.
module tb_par_ser;

`ifdef PAR_SER_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif
   localparam int         MC   = 4;
   localparam logic [7:0] IDLE = 8'hBC;

   logic       clk_32f = 1'b0;
   logic       reset = 1'b1;
   logic       valid_in = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       ready_out, data_out, byte_start, active;

   logic       reset2 = 1'b1;
   logic       valid2 = 1'b0;
   logic [7:0] data2 = 8'h00;
   logic       ready2, dout2, bs2, act2;

   always #5 clk_32f = ~clk_32f;

   par_ser #(.MIN_COMMA(MC), .IDLE_BYTE(IDLE)) dut (
      .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready_out), .data_out(data_out), .byte_start(byte_start), .active(active)
   );

   par_ser #(.MIN_COMMA(1), .IDLE_BYTE(IDLE)) dut1 (
      .clk_32f(clk_32f), .reset(reset2), .data_in(data2), .valid_in(valid2),
      .ready_out(ready2), .data_out(dout2), .byte_start(bs2), .active(act2)
   );

   int checks = 0;
   int errors = 0;

   // model: n = edges since reset release, mq = accepted but unsent bytes, cur = byte on the wire
   int         n = 0;
   logic [7:0] mq[$];
   logic [7:0] cur = 8'h00;
   int         first_act = -1;
   int         first_rdy = -1;
   logic [7:0] rx_sh = 8'h00;
   logic [7:0] rx_q[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, n);
      end
   endtask

   function automatic int model_ready();
      int run_now, load_now;
      run_now  = (n >= 8 * (MC - 1) + 1) ? 1 : 0;
      load_now = (n % 8 == 0) ? 1 : 0;
      return (run_now != 0 && (mq.size() < DEPTH || (load_now != 0 && mq.size() > 0))) ? 1 : 0;
   endfunction

   task automatic check_outputs();
      int k;
      if (n == 0) begin
         check("rst_data_out", int'(data_out), 0);
         check("rst_byte_start", int'(byte_start), 0);
         check("rst_active", int'(active), 0);
         check("rst_ready_out", int'(ready_out), 0);
      end else begin
         k = (n - 1) % 8;
         check("data_out", int'(data_out), int'(cur[7-k]));
         check("byte_start", int'(byte_start), (k == 0) ? 1 : 0);
         check("active", int'(active), ((n - 1) / 8 >= MC) ? 1 : 0);
         if (active && first_act < 0) first_act = n;
         rx_sh = {rx_sh[6:0], data_out};
         if (k == 7) rx_q.push_back(rx_sh);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [7:0] d, output logic acc);
      int exp_rdy;
      reset = r; valid_in = v; data_in = d;
      #1;
      exp_rdy = model_ready();
      acc = 1'b0;
      if (r) begin
         n = 0; mq.delete(); cur = 8'h00; first_act = -1; first_rdy = -1;
      end else begin
         check("ready_out", int'(ready_out), exp_rdy);
         if (ready_out && first_rdy < 0) first_rdy = n;
         acc = v && (exp_rdy != 0);
         if (n % 8 == 0) begin
            if (n >= 8 * (MC - 1) + 1 && mq.size() > 0) cur = mq.pop_front();
            else cur = IDLE;
         end
         if (acc) mq.push_back(d);
         n++;
      end
      @(posedge clk_32f);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int cyc);
      logic a;
      for (int i = 0; i < cyc; i++) step(1'b0, 1'b0, 8'h00, a);
   endtask

   task automatic send(input logic [7:0] d, output int used);
      logic a;
      a = 1'b0;
      used = 0;
      while (!a && used < 40) begin
         step(1'b0, 1'b1, d, a);
         used++;
      end
      if (!a) check("send_timeout", 0, 1);
   endtask

   function automatic int first_data_idx();
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] != IDLE) return i;
      return -1;
   endfunction

   initial begin
      logic a;
      int used, total, idx, found;
      logic pend;
      logic [7:0] pd;
      logic [7:0] lo2, hi2;

      // reset, then the comma run
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, a);
      idle(40);
      check("a_rx_bytes", rx_q.size(), 5);
      for (int i = 0; i < 4; i++) check("a_comma_byte", int'(rx_q[i]), 8'hBC);
      check("a_active_rise", first_act, 33);
      check("a_ready_rise", first_rdy, 25);

      // single byte 0x5A
      rx_q.delete();
      send(8'h5A, used);
      idle(24);
      idx = first_data_idx();
      if (idx < 0) check("b_data_seen", 0, 1);
      else begin
         check("b_data_byte", int'(rx_q[idx]), 8'h5A);
         if (idx + 1 < rx_q.size()) check("b_then_idle", int'(rx_q[idx+1]), 8'hBC);
         else check("b_then_idle_seen", 0, 1);
      end

      // back-to-back with valid held high
      rx_q.delete();
      total = 0;
      send(8'h01, used); total += used;
      send(8'h80, used); total += used;
      send(8'hFF, used); total += used;
      idle(40);
`ifdef PAR_SER_FIFO_EN
      check("c_accept_cycles", total, 3);
`endif
      idx = first_data_idx();
      if (idx < 0 || idx + 2 >= rx_q.size()) check("c_data_seen", 0, 1);
      else begin
         check("c_byte0", int'(rx_q[idx]), 8'h01);
         check("c_byte1", int'(rx_q[idx+1]), 8'h80);
         check("c_byte2", int'(rx_q[idx+2]), 8'hFF);
      end

      // idle-valued data byte
      send(8'hBC, used);
      idle(16);
      check("d_active_kept", int'(active), 1);

      // reset in the middle of 0xC3 with 0x3C queued behind it
      send(8'hC3, used);
      send(8'h3C, used);
      for (int i = 0; i < 40; i++) begin
         if ((n - 1) % 8 == 3 && cur == 8'hC3 && mq.size() == 1) break;
         step(1'b0, 1'b0, 8'h00, a);
      end
      if (!((n - 1) % 8 == 3 && cur == 8'hC3 && mq.size() == 1)) check("e_reach_bit4", 0, 1);
      step(1'b1, 1'b0, 8'h00, a);
      check("e_rst_data_out", int'(data_out), 0);
      check("e_rst_active", int'(active), 0);
      rx_q.delete();
      idle(48);
      found = 0;
      foreach (rx_q[i]) if (rx_q[i] != IDLE) found++;
      check("e_no_stale_bytes", found, 0);
      check("e_rx_bytes", rx_q.size(), 6);
      check("e_active_rise", first_act, 33);

      // randomized traffic with occasional resets; upstream holds a byte until accepted
      pend = 1'b0;
      pd = 8'h00;
      for (int i = 0; i < 2000; i++) begin
         if (!pend && $urandom_range(0, 2) == 0) begin
            pend = 1'b1;
            pd = 8'($urandom);
         end
         if ($urandom_range(0, 499) == 0) step(1'b1, pend, pd, a);
         else step(1'b0, pend, pd, a);
         if (a) pend = 1'b0;
      end
      idle(8);

      // MIN_COMMA = 1 instance
      reset = 1'b1; valid_in = 1'b0;
      reset2 = 1'b1;
      @(posedge clk_32f); @(posedge clk_32f); #1;
      reset2 = 1'b0;
      lo2 = 8'h00; hi2 = 8'h00;
      for (int e = 1; e <= 16; e++) begin
         if (e == 2) begin
            valid2 = 1'b1; data2 = 8'hA5;
         end
         #1;
         if (e == 2) check("g_ready_slot2", int'(ready2), 1);
         a = valid2 && ready2;
         @(posedge clk_32f); #1;
         if (a) valid2 = 1'b0;
         if (e <= 8) lo2 = {lo2[6:0], dout2};
         else hi2 = {hi2[6:0], dout2};
         if (e == 8) check("g_active_before", int'(act2), 0);
         if (e == 9) begin
            check("g_active_rise", int'(act2), 1);
            check("g_byte_start", int'(bs2), 1);
         end
      end
      check("g_first_comma", int'(lo2), 8'hBC);
      check("g_first_data", int'(hi2), 8'hA5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
